// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
//   Shared definitions for the instruction producer/decoder pair:
//   RV32I opcode constants for the supported classes, the op_class
//   enumeration and the field-packing function used by the encoder.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        CLS_R      = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } op_class_e;

    // Packs the structured fields into a 32-bit word. Fields a format
    // does not use are simply not referenced for that class. For
    // BRANCH, imm[0] is dropped (offsets are multiples of 2).
    function automatic logic [INSTR_W-1:0] encode_instr(
        input op_class_e  cls,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [2:0] funct3,
        input logic [6:0] funct7,
        input logic [12:0] imm
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        case (cls)
            CLS_R:      w = {funct7, rs2, rs1, funct3, rd, OPC_R};
            CLS_LOAD:   w = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            CLS_STORE:  w = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], OPC_BRANCH};
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// sync_fifo
//   Single-clock FIFO holding encoded instruction words.
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     push_i        write wdata_i (ignored when full)
//     wdata_i       write data
//     pop_i         drop the head entry (ignored when empty)
//     rdata_o       head entry, forced to 0 while empty
//     full_o        no free entry
//     empty_o       no valid entry
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Head is gated so the output reads 0 when nothing is buffered.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs RV32I R/LOAD/STORE/BRANCH fields into instruction words,
//   buffers them in a FIFO and streams each word with its byte address.
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     in_valid/in_ready      request handshake (in_ready = FIFO not full)
//     op_class,rd,rs1,rs2,
//     funct3,funct7,imm      request fields
//     out_valid/out_ready    output handshake on the FIFO head
//     out_instr, out_addr    head word and its byte address
//     instr_count            completed output handshakes (wraps at 16 bits)
//     err_align              sticky: BRANCH accepted with imm[0]=1
//     err_range              sticky: LOAD/STORE imm not 12-bit signed
//   Build option: define ENCODER_IMM_CHECK_EN to enable the err_range
//   check; otherwise err_range is tied to 0.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                DEPTH     = 2,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       instr_count,
    output logic              err_align,
    output logic              err_range
);

    op_class_e          cls;
    logic [INSTR_W-1:0] enc_word;
    logic               fifo_full, fifo_empty;
    logic               push, pop;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               err_align_q, err_align_d;

    assign cls      = op_class_e'(op_class);
    assign enc_word = encode_instr(cls, rd, rs1, rs2, funct3, funct7, imm);

    // Push uses the full flag of the current cycle only, so a pop from a
    // full FIFO never frees a slot for the same edge.
    assign in_ready  = ~fifo_full;
    assign push      = in_valid & ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (enc_word),
        .pop_i   (pop),
        .rdata_o (out_instr),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Words leave in FIFO order, so the head's address is always the
    // running address counter; it advances only on a handshake.
    always_comb begin
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_align_d = err_align_q;
        if (pop) begin
            addr_d = addr_q + ADDR_W'(4);
            cnt_d  = cnt_q + 16'd1;
        end
        if (push && cls == CLS_BRANCH && imm[0])
            err_align_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= BASE_ADDR;
            cnt_q       <= '0;
            err_align_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_align_q <= err_align_d;
        end
    end

    assign out_addr    = addr_q;
    assign instr_count = cnt_q;
    assign err_align   = err_align_q;

`ifdef ENCODER_IMM_CHECK_EN
    logic err_range_q, err_range_d;

    // imm[12] != imm[11] means the value needs more than 12 signed bits.
    always_comb begin
        err_range_d = err_range_q;
        if (push && (cls == CLS_LOAD || cls == CLS_STORE) && (imm[12] != imm[11]))
            err_range_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_range_q <= 1'b0;
        else     err_range_q <= err_range_d;
    end

    assign err_range = err_range_q;
`else
    assign err_range = 1'b0;
`endif

endmodule
